// File: rtl/flash_bus_arbiter_pkg.sv
// Shared encodings for the flash bus arbiter: FSM states, owner codes and
// the saturating outstanding-request counter update.
package flash_bus_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OWN_A = 3'd1;
  localparam logic [2:0] ST_OWN_B = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // Saturates at 3 and holds at 0 on a stray ack rather than wrapping.
  function automatic logic [1:0] outstanding_update(input logic [1:0] cur,
                                                    input logic       accept,
                                                    input logic       ack);
    logic [1:0] res;
    res = cur;
    if (accept && !ack) begin
      if (cur != 2'd3) begin
        res = cur + 2'd1;
      end else begin
        res = cur;
      end
    end else if (ack && !accept) begin
      if (cur != 2'd0) begin
        res = cur - 2'd1;
      end else begin
        res = cur;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/flash_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the SPI flash controller; forces a
// CYC-low cycle between owners and lets data accesses preempt long fetch streams.
module flash_bus_arbiter
  import flash_bus_arbiter_pkg::*;
#(
  parameter int HOLD_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_a_cyc,
  input  logic        i_a_stb,
  input  logic [21:0] i_a_addr,
  output logic        o_a_stall,
  output logic        o_a_ack,
  output logic [31:0] o_a_data,
  input  logic        i_b_cyc,
  input  logic        i_b_stb,
  input  logic        i_b_cfg_stb,
  input  logic        i_b_we,
  input  logic [21:0] i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_stall,
  output logic        o_b_ack,
  output logic [31:0] o_b_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_cfg_stb,
  output logic        o_s_we,
  output logic [21:0] o_s_addr,
  output logic [31:0] o_s_data,
  input  logic        i_s_stall,
  input  logic        i_s_ack,
  input  logic [31:0] i_s_data,
  output logic [1:0]  o_owner,
  output logic        o_preempt
);

  localparam int              HOLD_W   = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic              HOLD_EN  = (HOLD_LIMIT != 0);

  logic [2:0]        state_r, state_next_s;
  logic [1:0]        last_owner_r, last_owner_next_s;
  logic [1:0]        outstanding_r, outstanding_next_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_next_s;
  logic              preempt_s;
  logic              accept_s;
  logic              ack_s;

  assign o_a_data = i_s_data;
  assign o_b_data = i_s_data;

  assign preempt_s = HOLD_EN && (state_r == ST_OWN_A) && i_a_cyc && i_b_cyc &&
                     (hold_cnt_r == HOLD_MAX);

  // Slave-side mux and master stall/ack routing for the current owner.
  always_comb begin
    o_s_cyc     = 1'b0;
    o_s_stb     = 1'b0;
    o_s_cfg_stb = 1'b0;
    o_s_we      = 1'b0;
    o_s_addr    = 22'd0;
    o_s_data    = 32'd0;
    o_a_stall   = 1'b1;
    o_a_ack     = 1'b0;
    o_b_stall   = 1'b1;
    o_b_ack     = 1'b0;
    o_owner     = OWNER_NONE;
    o_preempt   = 1'b0;
    case (state_r)
      ST_OWN_A: begin
        // The preempt cycle already behaves like the first drain cycle.
        o_s_cyc   = i_a_cyc;
        o_s_stb   = i_a_cyc && i_a_stb && !preempt_s;
        o_s_addr  = i_a_addr;
        o_a_stall = i_s_stall || preempt_s;
        o_a_ack   = i_a_cyc && i_s_ack;
        o_owner   = OWNER_A;
        o_preempt = preempt_s;
      end
      ST_DRAIN: begin
        o_s_cyc  = i_a_cyc;
        o_s_addr = i_a_addr;
        o_a_ack  = i_a_cyc && i_s_ack;
        o_owner  = OWNER_A;
      end
      ST_OWN_B: begin
        o_s_cyc     = i_b_cyc;
        o_s_stb     = i_b_cyc && i_b_stb;
        o_s_cfg_stb = i_b_cyc && i_b_cfg_stb;
        o_s_we      = i_b_we;
        o_s_addr    = i_b_addr;
        o_s_data    = i_b_data;
        o_b_stall   = i_s_stall;
        o_b_ack     = i_b_cyc && i_s_ack;
        o_owner     = OWNER_B;
      end
      default: begin
        o_owner = OWNER_NONE;
      end
    endcase
  end

  assign accept_s = o_s_cyc && (o_s_stb || o_s_cfg_stb) && !i_s_stall;
  assign ack_s    = o_s_cyc && i_s_ack;

  // Next-state, ownership history, outstanding and hold-count updates.
  always_comb begin
    state_next_s       = state_r;
    last_owner_next_s  = last_owner_r;
    outstanding_next_s = outstanding_update(outstanding_r, accept_s, ack_s);
    hold_cnt_next_s    = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        outstanding_next_s = 2'd0;
        hold_cnt_next_s    = HOLD_ZERO;
        if (i_a_cyc && (!i_b_cyc || (last_owner_r == OWNER_B))) begin
          state_next_s = ST_OWN_A;
        end else if (i_b_cyc) begin
          state_next_s = ST_OWN_B;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (!i_a_cyc) begin
          state_next_s       = ST_IDLE;
          last_owner_next_s  = OWNER_A;
          outstanding_next_s = 2'd0;
          hold_cnt_next_s    = HOLD_ZERO;
        end else if (preempt_s) begin
          state_next_s    = ST_DRAIN;
          hold_cnt_next_s = HOLD_ZERO;
        end else if (!i_b_cyc) begin
          hold_cnt_next_s = HOLD_ZERO;
        end else if (ack_s && (hold_cnt_r != HOLD_MAX)) begin
          hold_cnt_next_s = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_next_s = hold_cnt_r;
        end
      end
      ST_DRAIN: begin
        if (!i_a_cyc) begin
          state_next_s       = ST_IDLE;
          last_owner_next_s  = OWNER_A;
          outstanding_next_s = 2'd0;
        end else if (outstanding_r == 2'd0) begin
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_GAP: begin
        state_next_s       = ST_OWN_B;
        last_owner_next_s  = OWNER_A;
        outstanding_next_s = 2'd0;
      end
      ST_OWN_B: begin
        if (!i_b_cyc) begin
          state_next_s       = ST_IDLE;
          last_owner_next_s  = OWNER_B;
          outstanding_next_s = 2'd0;
        end else begin
          state_next_s = ST_OWN_B;
        end
      end
      default: begin
        state_next_s       = ST_IDLE;
        outstanding_next_s = 2'd0;
        hold_cnt_next_s    = HOLD_ZERO;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      last_owner_r  <= OWNER_B;
      outstanding_r <= 2'd0;
      hold_cnt_r    <= HOLD_ZERO;
    end else begin
      state_r       <= state_next_s;
      last_owner_r  <= last_owner_next_s;
      outstanding_r <= outstanding_next_s;
      hold_cnt_r    <= hold_cnt_next_s;
    end
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed cycle-by-cycle bench for flash_bus_arbiter with HOLD_LIMIT = 2.
module tb_flash_bus_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic        i_a_cyc, i_a_stb;
  logic [21:0] i_a_addr;
  logic        o_a_stall, o_a_ack;
  logic [31:0] o_a_data;
  logic        i_b_cyc, i_b_stb, i_b_cfg_stb, i_b_we;
  logic [21:0] i_b_addr;
  logic [31:0] i_b_data;
  logic        o_b_stall, o_b_ack;
  logic [31:0] o_b_data;
  logic        o_s_cyc, o_s_stb, o_s_cfg_stb, o_s_we;
  logic [21:0] o_s_addr;
  logic [31:0] o_s_data;
  logic        i_s_stall, i_s_ack;
  logic [31:0] i_s_data;
  logic [1:0]  o_owner;
  logic        o_preempt;

  int total;
  int bad;
  int a_acks;

  flash_bus_arbiter #(.HOLD_LIMIT(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_addr(i_a_addr),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_cfg_stb(i_b_cfg_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_data(o_b_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_cfg_stb(o_s_cfg_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data),
    .o_owner(o_owner), .o_preempt(o_preempt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_a_cyc = 1'b0; i_a_stb = 1'b0; i_a_addr = 22'd0;
    i_b_cyc = 1'b0; i_b_stb = 1'b0; i_b_cfg_stb = 1'b0; i_b_we = 1'b0;
    i_b_addr = 22'd0; i_b_data = 32'd0;
    i_s_stall = 1'b0; i_s_ack = 1'b0; i_s_data = 32'd0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    a_acks = 0;
    clear_inputs();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    settle();
    chk("rst_s_cyc", {31'd0, o_s_cyc}, 32'd0);
    chk("rst_s_stb", {31'd0, o_s_stb}, 32'd0);
    chk("rst_s_cfg", {31'd0, o_s_cfg_stb}, 32'd0);
    chk("rst_s_we", {31'd0, o_s_we}, 32'd0);
    chk("rst_acks", {30'd0, o_a_ack, o_b_ack}, 32'd0);
    chk("rst_preempt", {31'd0, o_preempt}, 32'd0);
    chk("rst_stalls", {30'd0, o_a_stall, o_b_stall}, 32'd3);
    chk("rst_owner", {30'd0, o_owner}, 32'd0);

    // A alone: four pipelined reads at 0x100..0x103
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 22'h100;
    settle();
    chk("t1_grant_wait", {31'd0, o_s_cyc}, 32'd0);
    chk("t1_wait_stall", {31'd0, o_a_stall}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      i_a_stb  = (i < 4) ? 1'b1 : 1'b0;
      i_a_addr = 22'h100 + 22'(i);
      i_s_ack  = (i > 0) ? 1'b1 : 1'b0;
      i_s_data = 32'hA000_0000 + 32'(i);
      settle();
      if (o_a_ack === 1'b1) a_acks = a_acks + 1;
      chk("t1_s_cyc", {31'd0, o_s_cyc}, 32'd1);
      chk("t1_owner", {30'd0, o_owner}, 32'd1);
      chk("t1_b_ack", {31'd0, o_b_ack}, 32'd0);
      chk("t1_a_ack", {31'd0, o_a_ack}, (i > 0) ? 32'd1 : 32'd0);
      chk("t1_s_stb", {31'd0, o_s_stb}, (i < 4) ? 32'd1 : 32'd0);
      chk("t1_addr", {10'd0, o_s_addr}, 32'h100 + 32'(i));
      chk("t1_a_data", o_a_data, 32'hA000_0000 + 32'(i));
    end
    chk("t1_ack_count", 32'(a_acks), 32'd4);
    step();
    clear_inputs();
    settle();
    chk("t1_drop_s_cyc", {31'd0, o_s_cyc}, 32'd0);

    // Simultaneous request after reset: A first, then B via one IDLE cycle
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_a_cyc = 1'b1; i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_addr = 22'h200;
    settle();
    chk("t2_idle_cyc", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t2_owner_a", {30'd0, o_owner}, 32'd1);
    chk("t2_b_stall", {31'd0, o_b_stall}, 32'd1);
    chk("t2_addr_a", {10'd0, o_s_addr}, 32'd0);
    step();
    i_a_cyc = 1'b0;
    settle();
    chk("t2_a_drop", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t2_gap_owner", {30'd0, o_owner}, 32'd0);
    chk("t2_gap_cyc", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t2_owner_b", {30'd0, o_owner}, 32'd2);
    chk("t2_b_stb", {31'd0, o_s_stb}, 32'd1);
    chk("t2_b_addr", {10'd0, o_s_addr}, 32'h200);
    chk("t2_b_stall_lo", {31'd0, o_b_stall}, 32'd0);
    step();
    i_b_stb = 1'b0; i_s_ack = 1'b1; i_s_data = 32'hB000_0001;
    settle();
    chk("t2_b_ack", {30'd0, o_a_ack, o_b_ack}, 32'd1);
    chk("t2_b_data", o_b_data, 32'hB000_0001);
    step();
    clear_inputs();
    settle();
    chk("t2_b_drop", {31'd0, o_s_cyc}, 32'd0);

    // Preemption of an A stream by B after two held acks
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 22'h300;
    i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_addr = 22'h400;
    settle();
    chk("t3_idle", {31'd0, o_s_cyc}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      i_a_addr = 22'h300 + 22'(i);
      i_s_ack  = (i > 0) ? 1'b1 : 1'b0;
      settle();
      chk("t3_owner", {30'd0, o_owner}, 32'd1);
      chk("t3_s_cyc", {31'd0, o_s_cyc}, 32'd1);
      chk("t3_a_ack", {31'd0, o_a_ack}, (i > 0) ? 32'd1 : 32'd0);
      chk("t3_preempt", {31'd0, o_preempt}, (i == 3) ? 32'd1 : 32'd0);
      chk("t3_a_stall", {31'd0, o_a_stall}, (i == 3) ? 32'd1 : 32'd0);
      chk("t3_s_stb", {31'd0, o_s_stb}, (i == 3) ? 32'd0 : 32'd1);
    end
    step();
    i_s_ack = 1'b0;
    settle();
    chk("t3_drain_pre", {31'd0, o_preempt}, 32'd0);
    chk("t3_drain_stall", {31'd0, o_a_stall}, 32'd1);
    chk("t3_drain_stb", {31'd0, o_s_stb}, 32'd0);
    chk("t3_drain_cyc", {31'd0, o_s_cyc}, 32'd1);
    step();
    settle();
    chk("t3_gap_cyc", {31'd0, o_s_cyc}, 32'd0);
    chk("t3_gap_stalls", {30'd0, o_a_stall, o_b_stall}, 32'd3);
    chk("t3_gap_owner", {30'd0, o_owner}, 32'd0);
    step();
    settle();
    chk("t3_b_owner", {30'd0, o_owner}, 32'd2);
    chk("t3_b_addr", {10'd0, o_s_addr}, 32'h400);
    chk("t3_b_stb", {31'd0, o_s_stb}, 32'd1);
    chk("t3_a_stalled", {31'd0, o_a_stall}, 32'd1);
    step();
    i_b_stb = 1'b0; i_s_ack = 1'b1; i_s_data = 32'hB000_0400;
    settle();
    chk("t3_b_ack", {30'd0, o_a_ack, o_b_ack}, 32'd1);
    chk("t3_bcast", o_a_data, 32'hB000_0400);
    step();
    i_b_cyc = 1'b0; i_s_ack = 1'b0; i_a_stb = 1'b0;
    settle();
    chk("t3_b_drop", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t3_idle_again", {30'd0, o_owner}, 32'd0);
    step();
    settle();
    chk("t3_a_regain", {30'd0, o_owner}, 32'd1);
    chk("t3_a_addr", {10'd0, o_s_addr}, 32'h303);
    step();
    i_a_cyc = 1'b0;
    settle();
    chk("t3_a_drop", {31'd0, o_s_cyc}, 32'd0);

    // B config write is never preempted even with A waiting
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 22'h010;
    i_b_cyc = 1'b1; i_b_cfg_stb = 1'b1; i_b_we = 1'b1; i_b_data = 32'h0000_0012;
    settle();
    chk("t4_idle", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t4_owner_b", {30'd0, o_owner}, 32'd2);
    chk("t4_cfg_we", {30'd0, o_s_cfg_stb, o_s_we}, 32'd3);
    chk("t4_s_data", o_s_data, 32'h0000_0012);
    for (int i = 0; i < 5; i++) begin
      step();
      i_b_cfg_stb = 1'b0;
      i_s_ack = 1'b1;
      settle();
      chk("t4_hold_owner", {30'd0, o_owner}, 32'd2);
      chk("t4_no_preempt", {31'd0, o_preempt}, 32'd0);
      chk("t4_a_wait", {30'd0, o_a_stall, o_a_ack}, 32'd2);
      chk("t4_b_acked", {31'd0, o_b_ack}, 32'd1);
    end
    step();
    i_b_cyc = 1'b0; i_b_we = 1'b0; i_s_ack = 1'b0;
    settle();
    chk("t4_b_drop", {31'd0, o_s_cyc}, 32'd0);
    step();
    settle();
    chk("t4_idle_owner", {30'd0, o_owner}, 32'd0);

    // A drops cyc with one request outstanding; late ack goes nowhere
    step();
    settle();
    chk("t5_owner_a", {30'd0, o_owner}, 32'd1);
    chk("t5_s_stb", {31'd0, o_s_stb}, 32'd1);
    step();
    i_a_cyc = 1'b0; i_a_stb = 1'b0;
    settle();
    chk("t5_cyc_fall", {31'd0, o_s_cyc}, 32'd0);
    step();
    i_s_ack = 1'b1;
    settle();
    chk("t5_late_ack", {30'd0, o_a_ack, o_b_ack}, 32'd0);
    chk("t5_late_cyc", {31'd0, o_s_cyc}, 32'd0);

    // Reset during an accepted B strobe
    step();
    clear_inputs();
    i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_addr = 22'h500;
    settle();
    step();
    settle();
    chk("t6_owner_b", {30'd0, o_owner}, 32'd2);
    chk("t6_stb", {31'd0, o_s_stb}, 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    settle();
    chk("t6_rst_cyc", {31'd0, o_s_cyc}, 32'd0);
    chk("t6_rst_owner", {30'd0, o_owner}, 32'd0);
    chk("t6_rst_stalls", {30'd0, o_a_stall, o_b_stall}, 32'd3);
    step();
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
